// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: ALU op codes, RV32I major opcodes, widths.
// Helper maps funct3 onto the ALU op code.
package alu_pkg;

  localparam int XLEN_D = 32;
  localparam int RD_W_D = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // SLT/SLTU fall back to ADD; the caller flags them illegal.
  function automatic alu_op_e f3_op(
    input logic [2:0] f3,
    input logic       sub,
    input logic       sra
  );
    alu_op_e r;
    case (f3)
      3'b000:  r = sub ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b100:  r = ALU_XOR;
      3'b101:  r = sra ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      3'b111:  r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I opcode/funct to ALU op code and operand selection.
// Unsupported encodings produce zero operands with the illegal flag set.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_D
) (
  input  logic [6:0]      i_opcode7,
  input  logic [2:0]      i_funct3,
  input  logic            i_funct7b5,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_pc,
  output alu_op_e         o_op,
  output logic [XLEN-1:0] o_op_0,
  output logic [XLEN-1:0] o_op_1,
  output logic            o_illegal
);

  logic w_is_op;
  logic w_is_opimm;
  logic w_is_lui;
  logic w_is_auipc;
  logic w_is_mem;
  logic w_is_br;
  logic w_slt;

  assign w_is_op    = (i_opcode7 == OPC_OP);
  assign w_is_opimm = (i_opcode7 == OPC_OPIMM);
  assign w_is_lui   = (i_opcode7 == OPC_LUI);
  assign w_is_auipc = (i_opcode7 == OPC_AUIPC);
  assign w_is_mem   = (i_opcode7 == OPC_LOAD)
                    | (i_opcode7 == OPC_STORE);
  assign w_is_br    = (i_opcode7 == OPC_BRANCH);
  assign w_slt      = (i_funct3[2:1] == 2'b01);

  always_comb begin
    o_op      = ALU_ADD;
    o_op_0    = '0;
    o_op_1    = '0;
    o_illegal = 1'b0;
    unique case (1'b1)
      w_is_op: begin
        o_op_0    = i_rs1;
        o_op_1    = i_rs2;
        o_op      = f3_op(i_funct3, i_funct7b5, i_funct7b5);
        o_illegal = w_slt;
      end
      w_is_opimm: begin
        o_op_0    = i_rs1;
        o_op_1    = i_imm;
        o_op      = f3_op(i_funct3, 1'b0, i_funct7b5);
        o_illegal = w_slt;
      end
      w_is_lui: begin
        o_op_1 = i_imm;
      end
      w_is_auipc: begin
        o_op_0 = i_pc;
        o_op_1 = i_imm;
      end
      w_is_mem: begin
        o_op_0 = i_rs1;
        o_op_1 = i_imm;
      end
      w_is_br: begin
        o_op_0 = i_rs1;
        o_op_1 = i_rs2;
        o_op   = ALU_SUB;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode to operands, main reg + skid reg, registered in_ready.
// Optional ALU_ISSUE_FWD_EN adds a single write-back forwarding port.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int RD_W = RD_W_D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode7,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [RD_W-1:0] in_rd,
`ifdef ALU_ISSUE_FWD_EN
  input  logic            fw_valid,
  input  logic [RD_W-1:0] fw_rd,
  input  logic [XLEN-1:0] fw_data,
  input  logic [RD_W-1:0] in_rs1_idx,
  input  logic [RD_W-1:0] in_rs2_idx,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      alu_opcode,
  output logic [XLEN-1:0] alu_op_0,
  output logic [XLEN-1:0] alu_op_1,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal
);

  localparam int PW = 3 + 2 * XLEN + RD_W + 1;

  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;
  alu_op_e         w_op;
  logic [XLEN-1:0] w_op_0;
  logic [XLEN-1:0] w_op_1;
  logic            w_ill;
  logic [PW-1:0]   w_new;
  logic            w_acc;

  logic            r_main_v;
  logic            r_skid_v;
  logic [PW-1:0]   r_main;
  logic [PW-1:0]   r_skid;

`ifdef ALU_ISSUE_FWD_EN
  logic w_fw_hit;
  assign w_fw_hit = fw_valid && (fw_rd != '0);
  assign w_rs1 = (w_fw_hit && fw_rd == in_rs1_idx) ? fw_data : in_rs1_val;
  assign w_rs2 = (w_fw_hit && fw_rd == in_rs2_idx) ? fw_data : in_rs2_val;
`else
  assign w_rs1 = in_rs1_val;
  assign w_rs2 = in_rs2_val;
`endif

  alu_op_decode #(.XLEN(XLEN)) u_dec (
    .i_opcode7  (in_opcode7),
    .i_funct3   (in_funct3),
    .i_funct7b5 (in_funct7b5),
    .i_rs1      (w_rs1),
    .i_rs2      (w_rs2),
    .i_imm      (in_imm),
    .i_pc       (in_pc),
    .o_op       (w_op),
    .o_op_0     (w_op_0),
    .o_op_1     (w_op_1),
    .o_illegal  (w_ill)
  );

  assign w_new = {w_op, w_op_0, w_op_1, in_rd, w_ill};
  assign w_acc = in_valid & ~r_skid_v;

  // Flush wins over both accept and drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main   <= '0;
      r_skid   <= '0;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (!r_main_v || out_ready) begin
      if (r_skid_v) begin
        r_main   <= r_skid;
        r_main_v <= 1'b1;
        r_skid_v <= 1'b0;
      end else begin
        r_main_v <= w_acc;
        if (w_acc) r_main <= w_new;
      end
    end else if (w_acc) begin
      r_skid   <= w_new;
      r_skid_v <= 1'b1;
    end
  end

  assign in_ready  = ~r_skid_v;
  assign out_valid = r_main_v;
  assign {alu_opcode, alu_op_0, alu_op_1, out_rd, out_illegal} = r_main;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
// Define ALU_ISSUE_FWD_EN for both DUT and bench to cover forwarding.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode7;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_op_0;
  logic [31:0] alu_op_1;
  logic [4:0]  out_rd;
  logic        out_illegal;
`ifdef ALU_ISSUE_FWD_EN
  logic        fw_valid;
  logic [4:0]  fw_rd;
  logic [31:0] fw_data;
  logic [4:0]  in_rs1_idx;
  logic [4:0]  in_rs2_idx;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode7  (in_opcode7),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_rs1_val  (in_rs1_val),
    .in_rs2_val  (in_rs2_val),
    .in_imm      (in_imm),
    .in_pc       (in_pc),
    .in_rd       (in_rd),
`ifdef ALU_ISSUE_FWD_EN
    .fw_valid    (fw_valid),
    .fw_rd       (fw_rd),
    .fw_data     (fw_data),
    .in_rs1_idx  (in_rs1_idx),
    .in_rs2_idx  (in_rs2_idx),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_opcode  (alu_opcode),
    .alu_op_0    (alu_op_0),
    .alu_op_1    (alu_op_1),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  task automatic drive(input logic v, input logic [6:0] o,
                       input logic [2:0] f, input logic b,
                       input logic [31:0] a, input logic [31:0] bb,
                       input logic [31:0] im, input logic [31:0] p,
                       input logic [4:0] d);
    in_valid    = v;
    in_opcode7  = o;
    in_funct3   = f;
    in_funct7b5 = b;
    in_rs1_val  = a;
    in_rs2_val  = bb;
    in_imm      = im;
    in_pc       = p;
    in_rd       = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 7'h0, 3'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_hs rdy/vld=%b exp 10", {in_ready, out_valid});
    end
    checks++;
    if ({alu_opcode, alu_op_0, alu_op_1, out_rd, out_illegal} !== '0) begin
      errors++;
      $display("FAIL reset_data op=%h a=%h b=%h rd=%h ill=%b exp 0",
               alu_opcode, alu_op_0, alu_op_1, out_rd, out_illegal);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL idle_hs rdy/vld=%b exp 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_sub();
    drive(1'b1, 7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'h0, 32'h0, 5'd7);
    @(negedge clk);
    drive(1'b0, 7'h0, 3'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0);
    checks++;
    if ({out_valid, alu_opcode, alu_op_0, alu_op_1, out_rd, out_illegal} !==
        {1'b1, 3'b001, 32'd10, 32'd3, 5'd7, 1'b0}) begin
      errors++;
      $display("FAIL sub v=%b op=%b a=%h b=%h rd=%0d exp 1 001 a 3 7",
               out_valid, alu_opcode, alu_op_0, alu_op_1, out_rd);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sub_drain out_valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_auipc_illegal();
    drive(1'b1, 7'b0010111, 3'b000, 1'b0, 32'h5, 32'h6, 32'h2000, 32'h1000, 5'd1);
    @(negedge clk);
    drive(1'b1, 7'b1111111, 3'b000, 1'b0, 32'h5, 32'h6, 32'h7, 32'h8, 5'd2);
    checks++;
    if ({out_valid, alu_opcode, alu_op_0, alu_op_1, out_illegal} !==
        {1'b1, 3'b000, 32'h1000, 32'h2000, 1'b0}) begin
      errors++;
      $display("FAIL auipc v=%b op=%b a=%h b=%h ill=%b exp 1 000 1000 2000 0",
               out_valid, alu_opcode, alu_op_0, alu_op_1, out_illegal);
    end
    @(negedge clk);
    drive(1'b0, 7'h0, 3'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0);
    checks++;
    if ({out_valid, alu_opcode, alu_op_0, alu_op_1, out_rd, out_illegal} !==
        {1'b1, 3'b000, 32'h0, 32'h0, 5'd2, 1'b1}) begin
      errors++;
      $display("FAIL unknown v=%b op=%b a=%h b=%h rd=%0d ill=%b exp 1 000 0 0 2 1",
               out_valid, alu_opcode, alu_op_0, alu_op_1, out_rd, out_illegal);
    end
    @(negedge clk);
  endtask

  // Back-to-back decode table: rs1=11 rs2=22 imm=33 pc=44.
  task automatic test_decode_table();
    logic [6:0]  t_opc [11] = '{7'b0010011, 7'b0010011, 7'b0110011,
                                7'b0110011, 7'b0110111, 7'b0100011,
                                7'b1100011, 7'b0110011, 7'b0010011,
                                7'b0110011, 7'b0010011};
    logic [2:0]  t_f3  [11] = '{3'b000, 3'b101, 3'b101, 3'b011, 3'b000,
                                3'b010, 3'b001, 3'b111, 3'b100, 3'b110,
                                3'b001};
    logic        t_b5  [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0]  t_op  [11] = '{3'b000, 3'b111, 3'b110, 3'b000, 3'b000,
                                3'b000, 3'b001, 3'b010, 3'b100, 3'b011,
                                3'b101};
    logic [31:0] t_a   [11] = '{32'h11, 32'h11, 32'h11, 32'h11, 32'h0,
                                32'h11, 32'h11, 32'h11, 32'h11, 32'h11,
                                32'h11};
    logic [31:0] t_b   [11] = '{32'h33, 32'h33, 32'h22, 32'h22, 32'h33,
                                32'h33, 32'h22, 32'h22, 32'h33, 32'h22,
                                32'h33};
    logic        t_il  [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, t_opc[i], t_f3[i], t_b5[i], 32'h11, 32'h22, 32'h33,
            32'h44, 5'(i + 3));
      @(negedge clk);
      checks++;
      if ({out_valid, alu_opcode, alu_op_0, alu_op_1, out_rd, out_illegal} !==
          {1'b1, t_op[i], t_a[i], t_b[i], 5'(i + 3), t_il[i]}) begin
        errors++;
        $display("FAIL dec%0d v=%b op=%b a=%h b=%h rd=%0d ill=%b exp 1 %b %h %h %0d %b",
                 i, out_valid, alu_opcode, alu_op_0, alu_op_1, out_rd,
                 out_illegal, t_op[i], t_a[i], t_b[i], i + 3, t_il[i]);
      end
    end
    drive(1'b0, 7'h0, 3'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'hA, 32'h1, 32'h0, 32'h0, 5'd10);
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out_rd} !== {1'b1, 1'b1, 5'd10}) begin
      errors++;
      $display("FAIL bp_a v/rdy=%b%b rd=%0d exp 11 10", out_valid, in_ready, out_rd);
    end
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'hB, 32'h1, 32'h0, 32'h0, 5'd11);
    @(negedge clk);
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'hC, 32'h1, 32'h0, 32'h0, 5'd12);
    checks++;
    if ({in_ready, out_rd, alu_op_0} !== {1'b0, 5'd10, 32'hA}) begin
      errors++;
      $display("FAIL bp_full rdy=%b rd=%0d a=%h exp 0 10 a", in_ready, out_rd, alu_op_0);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out_rd, alu_op_0} !== {1'b1, 1'b0, 5'd10, 32'hA}) begin
      errors++;
      $display("FAIL bp_hold v/rdy=%b%b rd=%0d a=%h exp 10 10 a",
               out_valid, in_ready, out_rd, alu_op_0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out_rd, alu_op_0} !== {1'b1, 1'b1, 5'd11, 32'hB}) begin
      errors++;
      $display("FAIL bp_b v/rdy=%b%b rd=%0d a=%h exp 11 11 b",
               out_valid, in_ready, out_rd, alu_op_0);
    end
    @(negedge clk);
    drive(1'b0, 7'h0, 3'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0);
    checks++;
    if ({out_valid, out_rd, alu_op_0} !== {1'b1, 5'd12, 32'hC}) begin
      errors++;
      $display("FAIL bp_c v=%b rd=%0d a=%h exp 1 12 c", out_valid, out_rd, alu_op_0);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end out_valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'h1, 32'h1, 32'h0, 32'h0, 5'd20);
    @(negedge clk);
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'h2, 32'h1, 32'h0, 32'h0, 5'd21);
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL fl_full v/rdy=%b exp 10", {out_valid, in_ready});
    end
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'h3, 32'h1, 32'h0, 32'h0, 5'd22);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 7'h0, 3'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0);
    out_ready = 1'b1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL fl_clear v/rdy=%b exp 01", {out_valid, in_ready});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL fl_drop%0d out_valid=%b rd=%0d exp 0", i, out_valid, out_rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'h9, 32'h9, 32'h0, 32'h0, 5'd9);
    @(negedge clk);
    drive(1'b0, 7'h0, 3'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_rd, alu_op_0} !== {1'b0, 1'b1, 5'd0, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid v/rdy=%b%b rd=%0d a=%h exp 01 0 0",
               out_valid, in_ready, out_rd, alu_op_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

`ifdef ALU_ISSUE_FWD_EN
  task automatic test_fwd();
    fw_valid = 1'b1;
    fw_rd = 5'd5;
    fw_data = 32'hDEAD;
    in_rs1_idx = 5'd5;
    in_rs2_idx = 5'd5;
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'h1, 32'h2, 32'h0, 32'h0, 5'd3);
    @(negedge clk);
    fw_rd = 5'd0;
    in_rs1_idx = 5'd0;
    in_rs2_idx = 5'd0;
    checks++;
    if ({alu_op_0, alu_op_1} !== {32'hDEAD, 32'hDEAD}) begin
      errors++;
      $display("FAIL fwd_hit a=%h b=%h exp dead dead", alu_op_0, alu_op_1);
    end
    @(negedge clk);
    drive(1'b0, 7'h0, 3'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0);
    fw_valid = 1'b0;
    checks++;
    if ({alu_op_0, alu_op_1} !== {32'h1, 32'h2}) begin
      errors++;
      $display("FAIL fwd_x0 a=%h b=%h exp 1 2", alu_op_0, alu_op_1);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
`ifdef ALU_ISSUE_FWD_EN
    fw_valid = 1'b0;
    fw_rd = 5'd0;
    fw_data = 32'h0;
    in_rs1_idx = 5'd0;
    in_rs2_idx = 5'd0;
`endif
    test_reset();
    test_sub();
    test_auipc_illegal();
    test_decode_table();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef ALU_ISSUE_FWD_EN
    test_fwd();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
